// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file controller: command opcodes, FSM states
// and default data/address widths.
package regfile_ctrl_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 2;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_COPY  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RESP,
        CP_RD,
        CP_WR
    } state_e;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Command/response bus between a requester (master) and the register-file controller (slave).
interface regfile_ctrl_if #(
    parameter int DATA_W = regfile_ctrl_pkg::DATA_W_DEF,
    parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W_DEF
);
    import regfile_ctrl_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_src;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_src, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/regfile_ctrl.sv
// Register-file controller: one command in flight, WRITE / READ with response / optional COPY.
// Define REGFILE_CTRL_COPY_EN to enable COPY; otherwise op 11 is accepted and treated as NOP.
module regfile_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              clr,
    regfile_ctrl_if.slave     bus,
    output logic [DATA_W-1:0] rf_din,
    output logic [ADDR_W-1:0] rf_a_write,
    output logic              rf_en_decode,
    output logic              rf_crw,
    output logic [ADDR_W-1:0] rf_a_read,
    output logic              rf_en_tri,
    input  logic [DATA_W-1:0] rf_dout,
    output logic              busy
);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [DATA_W-1:0] rf_din_q, rf_din_d;
    logic [ADDR_W-1:0] rf_a_write_q, rf_a_write_d;
    logic              rf_wr_q, rf_wr_d;
    logic [ADDR_W-1:0] rf_a_read_q, rf_a_read_d;
    logic              rf_en_tri_q, rf_en_tri_d;

`ifdef REGFILE_CTRL_COPY_EN
    logic [ADDR_W-1:0] dst_q, dst_d;
`else
    // COPY source is meaningless without the COPY feature.
    logic unused_src;
    assign unused_src = ^bus.cmd_src;
`endif

    // All outputs are registered: next-state logic computes what the next cycle drives.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        cmd_ready_d  = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_data_d   = rsp_data_q;
        rf_din_d     = '0;
        rf_a_write_d = '0;
        rf_wr_d      = 1'b0;
        rf_a_read_d  = '0;
        rf_en_tri_d  = 1'b0;
`ifdef REGFILE_CTRL_COPY_EN
        dst_d        = dst_q;
`endif
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    unique case (bus.cmd_op)
                        OP_WRITE: begin
                            state_d      = WR;
                            cmd_ready_d  = 1'b0;
                            rf_wr_d      = 1'b1;
                            rf_a_write_d = bus.cmd_addr;
                            rf_din_d     = bus.cmd_data;
                        end
                        OP_READ: begin
                            state_d     = RD;
                            cmd_ready_d = 1'b0;
                            rf_en_tri_d = 1'b1;
                            rf_a_read_d = bus.cmd_addr;
                        end
`ifdef REGFILE_CTRL_COPY_EN
                        OP_COPY: begin
                            state_d     = CP_RD;
                            cmd_ready_d = 1'b0;
                            rf_en_tri_d = 1'b1;
                            rf_a_read_d = bus.cmd_src;
                            dst_d       = bus.cmd_addr;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            WR: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
            RD: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = rf_dout;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
`ifdef REGFILE_CTRL_COPY_EN
            CP_RD: begin
                // The captured value lives in the write-data register for the CP_WR cycle.
                state_d      = CP_WR;
                rf_wr_d      = 1'b1;
                rf_a_write_d = dst_q;
                rf_din_d     = rf_dout;
            end
            CP_WR: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
`endif
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rf_din_q     <= '0;
            rf_a_write_q <= '0;
            rf_wr_q      <= 1'b0;
            rf_a_read_q  <= '0;
            rf_en_tri_q  <= 1'b0;
`ifdef REGFILE_CTRL_COPY_EN
            dst_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rf_din_q     <= rf_din_d;
            rf_a_write_q <= rf_a_write_d;
            rf_wr_q      <= rf_wr_d;
            rf_a_read_q  <= rf_a_read_d;
            rf_en_tri_q  <= rf_en_tri_d;
`ifdef REGFILE_CTRL_COPY_EN
            dst_q        <= dst_d;
`endif
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign rf_din        = rf_din_q;
    assign rf_a_write    = rf_a_write_q;
    assign rf_en_decode  = rf_wr_q;
    assign rf_crw        = rf_wr_q;
    assign rf_a_read     = rf_a_read_q;
    assign rf_en_tri     = rf_en_tri_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width.
REQ-002 SHALL have parameter ADDR_W, default 2, register address width (4 registers).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, shared with register file.
REQ-005 clr  input  1  synchronous active-high reset.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_op  input  2  00 NOP, 01 WRITE, 10 READ, 11 COPY.
REQ-009 cmd_addr  input  ADDR_W  WRITE/COPY destination; READ source.
REQ-010 cmd_src  input  ADDR_W  COPY source.
REQ-011 cmd_data  input  DATA_W  WRITE data.
REQ-012 rsp_valid  output  1  read data available.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
REQ-014 rsp_data  output  DATA_W  read data, stable while rsp_valid.
REQ-015 rf_din, rf_a_write, rf_en_decode, rf_crw  output  DATA_W/ADDR_W/1/1  register-file write port; rf_crw=1 means write.
REQ-016 rf_a_read, rf_en_tri  output  ADDR_W/1  register-file read select and tristate enable.
REQ-017 rf_dout  input  DATA_W  register-file read data.
REQ-018 busy  output  1  high in any state other than IDLE.

Function
REQ-019 FSM states SHALL be IDLE, WR, RD, RESP, CP_RD, CP_WR.
REQ-020 cmd_ready SHALL be 1 only in IDLE; one command in flight at a time.
REQ-021 IDLE: accepted NOP stays IDLE; WRITE->WR; READ->RD; COPY->CP_RD; operands latched at acceptance.
REQ-022 WR SHALL last exactly one cycle: rf_en_decode=1, rf_crw=1, rf_a_write=latched addr, rf_din=latched data; then IDLE; no response generated.
REQ-023 RD SHALL last exactly one cycle: rf_en_tri=1, rf_a_read=latched addr; rf_dout captured into rsp_data at end of cycle; then RESP.
REQ-024 RESP: rsp_valid=1 until rsp_ready sampled high; then IDLE; rsp_data held unchanged throughout.
REQ-025 CP_RD one cycle reading cmd_src (as RD, capture into internal data register), then CP_WR one cycle writing captured value to cmd_addr (as WR); then IDLE; no response.
REQ-026 COPY with src==dst SHALL execute normally (rewrite same value).
REQ-027 Outside WR/CP_WR, rf_en_decode=0 and rf_crw=0; outside RD/CP_RD, rf_en_tri=0.
REQ-028 Latency: WRITE visible in register file 2 cycles after acceptance; READ rsp_valid 2 cycles after acceptance; COPY completes 3 cycles after acceptance.
REQ-029 rsp_ready while rsp_valid=0 SHALL be ignored.

Reset
REQ-030 clr SHALL force IDLE; cmd_ready=0 during clr cycle, 1 the cycle after.
REQ-031 On clr all other outputs SHALL be 0 (rsp_valid, rsp_data, busy, all rf_* outputs).
REQ-032 clr mid-operation SHALL drop the in-flight command and any pending response; no partial write issued after clr.

Configuration
REQ-033 Macro REGFILE_CTRL_COPY_EN: defined -> COPY per REQ-025; undefined -> CP_RD/CP_WR absent, op 11 accepted and treated as NOP.

Structure
REQ-034 Package regfile_ctrl_pkg SHALL hold op encodings, FSM state typedef, default DATA_W/ADDR_W constants.
REQ-035 No sub-module; FSM and datapath registers in one module.

Verification
REQ-036 WRITE addr 2 data 0xA5 -> cycle+1: rf_en_decode=1, rf_crw=1, rf_a_write=2, rf_din=0xA5 for one cycle only.
REQ-037 READ addr 2 with rf_dout model returning 0xA5 -> rf_en_tri=1, rf_a_read=2 one cycle; rsp_valid with rsp_data=0xA5 next cycle.
REQ-038 READ with rsp_ready low 5 cycles -> rsp_valid and rsp_data held; cmd_ready=0 throughout; IDLE after handshake.
REQ-039 COPY src 1 (holds 0x3C) dst 3 (COPY_EN defined) -> read of 1, then write 0x3C to 3; no rsp_valid; undefined -> no rf activity.
REQ-040 clr asserted in RD -> next cycle all outputs 0, no response; following WRITE 0x11 to addr 0 executes normally.
REQ-041 Back-to-back commands with cmd_valid held -> each accepted only in IDLE; NOP accepted in one cycle with no rf activity.
